mc_control_fsm: RTL

Multicycle controller for the 16-bit datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, including the 2-bit `pc_src` select of the three-input PC-source mux. Memory accesses use a ready handshake, so the FSM waits on slow memory.

---
 rtl/mc_control_fsm.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle controller for the 16-bit datapath: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select.
module mc_control_fsm #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BEQEX  = 4'd10,
    S_JEX    = 4'd11
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q;
  state_t     state_next;
  logic [3:0] opcode;
  logic [2:0] funct;
  logic       branch_q;
  logic       jump_q;
  logic       fetch_go;
  logic       unused_instr_bits;

  logic       d_iord;
  logic       d_mem_read;
  logic       d_mem_write;
  logic       d_reg_dst;
  logic       d_mem_to_reg;
  logic       d_reg_write;
  logic       d_alu_src_a;
  logic [1:0] d_alu_src_b;
  logic [2:0] d_alu_control;
  logic [1:0] d_pc_src;
  logic       d_branch;
  logic       d_jump;

  assign opcode            = instr[15:12];
  assign funct             = instr[2:0];
  assign unused_instr_bits = ^instr[11:3];

  // Next-state logic; mem_ready only matters in the three memory-wait states
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      default:  state_next = S_FETCH;
    endcase
  end

  // Moore decode of the upcoming state, so the registered outputs line up with state_q
  always_comb begin
    d_iord        = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_reg_dst     = 1'b0;
    d_mem_to_reg  = 1'b0;
    d_reg_write   = 1'b0;
    d_alu_src_a   = 1'b0;
    d_alu_src_b   = 2'b00;
    d_alu_control = ALU_ADD;
    d_pc_src      = 2'b00;
    d_branch      = 1'b0;
    d_jump        = 1'b0;
    case (state_next)
      S_FETCH: begin
        d_mem_read  = 1'b1;
        d_alu_src_b = 2'b01;
      end
      S_DECODE: d_alu_src_b = 2'b10;
      S_MEMADR, S_ADDIEX: begin
        d_alu_src_a = 1'b1;
        d_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        d_iord     = 1'b1;
        d_mem_read = 1'b1;
      end
      S_MEMWB: begin
        d_mem_to_reg = 1'b1;
        d_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        d_iord      = 1'b1;
        d_mem_write = 1'b1;
      end
      S_EXEC: begin
        d_alu_src_a = 1'b1;
        case (funct)
          3'b001:  d_alu_control = ALU_SUB;
          3'b010:  d_alu_control = ALU_AND;
          3'b011:  d_alu_control = ALU_OR;
          3'b100:  d_alu_control = ALU_SLT;
          default: d_alu_control = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        d_reg_dst   = 1'b1;
        d_reg_write = 1'b1;
      end
      S_ADDIWB: d_reg_write = 1'b1;
      S_BEQEX: begin
        d_alu_src_a   = 1'b1;
        d_alu_control = ALU_SUB;
        d_branch      = 1'b1;
        d_pc_src      = 2'b01;
      end
      S_JEX: begin
        d_jump   = 1'b1;
        d_pc_src = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      iord        <= 1'b0;
      mem_read    <= 1'b1;
      mem_write   <= 1'b0;
      reg_dst     <= 1'b0;
      mem_to_reg  <= 1'b0;
      reg_write   <= 1'b0;
      alu_src_a   <= 1'b0;
      alu_src_b   <= 2'b01;
      alu_control <= ALU_ADD;
      pc_src      <= 2'b00;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
    end else begin
      state_q     <= state_next;
      iord        <= d_iord;
      mem_read    <= d_mem_read;
      mem_write   <= d_mem_write;
      reg_dst     <= d_reg_dst;
      mem_to_reg  <= d_mem_to_reg;
      reg_write   <= d_reg_write;
      alu_src_a   <= d_alu_src_a;
      alu_src_b   <= d_alu_src_b;
      alu_control <= d_alu_control;
      pc_src      <= d_pc_src;
      branch_q    <= d_branch;
      jump_q      <= d_jump;
    end
  end

  // Fetch completion follows mem_ready directly; held off while reset is asserted
  assign fetch_go = (state_q == S_FETCH) && mem_ready && reset_n;
  assign ir_write = fetch_go;
  assign pc_en    = fetch_go || jump_q || (branch_q && zero);
  assign illegal  = (state_q == S_DECODE) && (opcode > OP_J);
  assign state    = 4'(state_q);

endmodule
